// File: rtl/wt_cache_pkg.sv
// Shared types, L15 size codes and the store piece selector for the write-through L1D path.
// The byte-only selection variant is requested through the byte_only argument of next_piece.
package wt_cache_pkg;

  localparam logic [1:0] L15_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] L15_SIZE_HWORD = 2'b01;
  localparam logic [1:0] L15_SIZE_WORD  = 2'b10;
  localparam logic [1:0] L15_SIZE_DWORD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

  typedef struct packed {
    logic [2:0] offset;
    logic [1:0] size;
    logic [7:0] be;
  } piece_t;

  // Masks the L15 can carry as a single transaction of one size.
  function automatic logic is_l15_full_mask(input logic [7:0] be);
    case (be)
      8'hFF, 8'h0F, 8'hF0, 8'h03, 8'h0C, 8'h30, 8'hC0: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Next naturally aligned piece starting at the lowest pending byte.
  function automatic piece_t next_piece(input logic [7:0] pend, input logic byte_only);
    piece_t     p;
    logic [2:0] idx;
    logic [7:0] m4;
    logic [7:0] m2;
    logic [7:0] m1;
    p   = '0;
    idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (pend[k]) idx = 3'(k);
    end
    m4 = 8'h0F << idx;
    m2 = 8'h03 << idx;
    m1 = 8'h01 << idx;
    p.offset = idx;
    if (pend == 8'h00) begin
      p = '0;
    end else if (byte_only) begin
      p.size = L15_SIZE_BYTE;
      p.be   = m1;
    end else if (pend == 8'hFF) begin
      p.size = L15_SIZE_DWORD;
      p.be   = 8'hFF;
    end else if ((idx[1:0] == 2'b00) && ((pend & m4) == m4)) begin
      p.size = L15_SIZE_WORD;
      p.be   = m4;
    end else if ((idx[0] == 1'b0) && ((pend & m2) == m2)) begin
      p.size = L15_SIZE_HWORD;
      p.be   = m2;
    end else begin
      p.size = L15_SIZE_BYTE;
      p.be   = m1;
    end
    return p;
  endfunction

endpackage

// File: rtl/wt_store_chunk_sel.sv
// Combinational piece selector: picks the next L15-legal store piece from the pending byte mask.
// WT_STORE_SPLIT_BYTE_ONLY_EN: only whole dword/word/hword requests merge, everything else goes bytewise.
module wt_store_chunk_sel
  import wt_cache_pkg::*;
(
  input  logic [7:0] pending_be_i,
`ifdef WT_STORE_SPLIT_BYTE_ONLY_EN
  input  logic [7:0] req_be_i,
`endif
  output logic [2:0] offset_o,
  output logic [1:0] size_o,
  output logic [7:0] be_o,
  output logic       last_o
);

  logic   w_byte_only;
  piece_t w_piece;

`ifdef WT_STORE_SPLIT_BYTE_ONLY_EN
  // The original mask decides; a partially drained mask may look legal but must stay bytewise.
  assign w_byte_only = !is_l15_full_mask(req_be_i);
`else
  assign w_byte_only = 1'b0;
`endif

  always_comb begin
    w_piece = next_piece(pending_be_i, w_byte_only);
  end

  assign offset_o = w_piece.offset;
  assign size_o   = w_piece.size;
  assign be_o     = w_piece.be;
  assign last_o   = ((pending_be_i & ~w_piece.be) == 8'h00);

endmodule

// File: rtl/wt_l15_store_splitter.sv
// Splits one 64-bit masked store into aligned L15 pieces sharing the original TID.
// WT_STORE_SPLIT_BYTE_ONLY_EN selects the byte-only piece selection in wt_store_chunk_sel.
//
// state    | meaning
// ST_IDLE  | ready for a new store; empty masks are accepted and dropped
// ST_SPLIT | presenting pieces from the pending mask until the last one handshakes
module wt_l15_store_splitter
  import wt_cache_pkg::*;
#(
  parameter int PADDR_W = 56,
  parameter int TID_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PADDR_W-1:0] req_paddr_i,
  input  logic [63:0]        req_data_i,
  input  logic [7:0]         req_be_i,
  input  logic [TID_W-1:0]   req_tid_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PADDR_W-1:0] out_paddr_o,
  output logic [63:0]        out_data_o,
  output logic [1:0]         out_size_o,
  output logic [7:0]         out_be_o,
  output logic [TID_W-1:0]   out_tid_o,
  output logic               out_last_o,
  output logic               busy_o
);

  split_state_t       r_state;
  split_state_t       w_state_nxt;
  logic [7:0]         r_pend_be;
  logic [PADDR_W-1:3] r_addr_hi;
  logic [63:0]        r_data;
  logic [TID_W-1:0]   r_tid;
  logic [2:0]         w_offset;
  logic [1:0]         w_size;
  logic [7:0]         w_be;
  logic               w_last;
  logic               w_accept;
  logic               w_hs;

  assign w_accept = (r_state == ST_IDLE) && req_valid_i && (req_be_i != 8'h00);
  assign w_hs     = (r_state == ST_SPLIT) && out_ready_i;

`ifdef WT_STORE_SPLIT_BYTE_ONLY_EN
  logic [7:0] r_req_be;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_req_be <= '0;
    else if (w_accept) r_req_be <= req_be_i;
  end
`endif

  wt_store_chunk_sel u_chunk_sel (
    .pending_be_i (r_pend_be),
`ifdef WT_STORE_SPLIT_BYTE_ONLY_EN
    .req_be_i     (r_req_be),
`endif
    .offset_o     (w_offset),
    .size_o       (w_size),
    .be_o         (w_be),
    .last_o       (w_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)        w_state_nxt = ST_SPLIT;
      ST_SPLIT: if (w_hs && w_last)  w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      ST_IDLE: req_ready_o = 1'b1;
      ST_SPLIT: begin
        out_valid_o = 1'b1;
        out_last_o  = w_last;
        busy_o      = 1'b1;
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend_be <= '0;
      r_addr_hi <= '0;
      r_data    <= '0;
      r_tid     <= '0;
    end else if (w_accept) begin
      r_pend_be <= req_be_i;
      r_addr_hi <= req_paddr_i[PADDR_W-1:3];
      r_data    <= req_data_i;
      r_tid     <= req_tid_i;
    end else if (w_hs) begin
      r_pend_be <= r_pend_be & ~w_be;
    end
  end

  assign out_paddr_o = {r_addr_hi, w_offset};
  assign out_data_o  = r_data;
  assign out_size_o  = w_size;
  assign out_be_o    = w_be;
  assign out_tid_o   = r_tid;

endmodule

// File: tb/tb_wt_l15_store_splitter.sv
// Self-checking bench for wt_l15_store_splitter: directed scenarios plus a random scoreboard run.
// Expected pieces follow WT_STORE_SPLIT_BYTE_ONLY_EN when the bench is built with it.
module tb_wt_l15_store_splitter;

  localparam int PADDR_W = 56;
  localparam int TID_W   = 2;

  typedef struct {
    logic [PADDR_W-1:0] paddr;
    logic [1:0]         size;
    logic [7:0]         be;
    logic               last;
    logic [TID_W-1:0]   tid;
    logic [63:0]        data;
    int                 pc;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [PADDR_W-1:0] req_paddr_i;
  logic [63:0]        req_data_i;
  logic [7:0]         req_be_i;
  logic [TID_W-1:0]   req_tid_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [PADDR_W-1:0] out_paddr_o;
  logic [63:0]        out_data_o;
  logic [1:0]         out_size_o;
  logic [7:0]         out_be_o;
  logic [TID_W-1:0]   out_tid_o;
  logic               out_last_o;
  logic               busy_o;

  int   total = 0;
  int   bad = 0;
  int   n_hs = 0;
  int   pieces_in_req = 0;
  int   prev_off = -1;
  bit   ready_mode = 1'b0;
  bit   r_fixed = 1'b1;
  exp_t q_exp[$];

  wt_l15_store_splitter #(.PADDR_W(PADDR_W), .TID_W(TID_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_paddr_i (req_paddr_i),
    .req_data_i  (req_data_i),
    .req_be_i    (req_be_i),
    .req_tid_i   (req_tid_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_paddr_o (out_paddr_o),
    .out_data_o  (out_data_o),
    .out_size_o  (out_size_o),
    .out_be_o    (out_be_o),
    .out_tid_o   (out_tid_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    if (ready_mode) out_ready_i = ($urandom_range(3) != 0);
    else            out_ready_i = r_fixed;
  end

  // Scoreboard: every handshaken piece is checked against the model queue.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      exp_t e;
      int   off;
      int   sz;
      n_hs++;
      off = int'(out_paddr_o[2:0]);
      sz  = 1 << out_size_o;
      total++;
      if (q_exp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_piece: got paddr=%h be=%h, no piece expected", out_paddr_o, out_be_o);
      end else begin
        e = q_exp.pop_front();
        if ({out_paddr_o, out_size_o, out_be_o, out_last_o, out_tid_o, out_data_o} !==
            {e.paddr, e.size, e.be, e.last, e.tid, e.data}) begin
          bad++;
          $display("FAIL piece: got paddr=%h size=%b be=%h last=%b tid=%h data=%h, want paddr=%h size=%b be=%h last=%b tid=%h data=%h",
                   out_paddr_o, out_size_o, out_be_o, out_last_o, out_tid_o, out_data_o,
                   e.paddr, e.size, e.be, e.last, e.tid, e.data);
        end
        total++;
        if ((off % sz) != 0 || out_be_o !== 8'(((1 << sz) - 1) << off)) begin
          bad++;
          $display("FAIL alignment: got off=%0d size=%0d be=%h, want aligned contiguous lanes", off, sz, out_be_o);
        end
        total++;
        if (pieces_in_req != 0 && off <= prev_off) begin
          bad++;
          $display("FAIL ascending: got off=%0d, want > %0d", off, prev_off);
        end
        pieces_in_req++;
        prev_off = off;
        if (out_last_o) begin
          total++;
          if (pieces_in_req > e.pc) begin
            bad++;
            $display("FAIL piece_count: got %0d, want <= %0d", pieces_in_req, e.pc);
          end
          pieces_in_req = 0;
          prev_off = -1;
        end
      end
    end
  end

  function automatic int popcnt8(input logic [7:0] v);
    int c = 0;
    for (int k = 0; k < 8; k++) if (v[k]) c++;
    return c;
  endfunction

  task automatic push_piece(input logic [PADDR_W-1:0] a, input int off, input int sz, input logic lst,
                            input logic [TID_W-1:0] tid, input logic [63:0] d, input int pc);
    exp_t e;
    e.paddr = {a[PADDR_W-1:3], 3'(off)};
    e.size  = (sz == 8) ? 2'b11 : (sz == 4) ? 2'b10 : (sz == 2) ? 2'b01 : 2'b00;
    e.be    = 8'(((1 << sz) - 1) << off);
    e.last  = lst;
    e.tid   = tid;
    e.data  = d;
    e.pc    = pc;
    q_exp.push_back(e);
  endtask

  task automatic push_expected(input logic [PADDR_W-1:0] a, input logic [7:0] be,
                               input logic [TID_W-1:0] tid, input logic [63:0] d);
    logic [7:0] rem;
    int         pc;
    int         lo;
    pc  = popcnt8(be);
    rem = be;
`ifdef WT_STORE_SPLIT_BYTE_ONLY_EN
    lo = 0;
    for (int k = 7; k >= 0; k--) if (be[k]) lo = k;
    if (be == 8'hFF) push_piece(a, 0, 8, 1'b1, tid, d, pc);
    else if (be == 8'h0F || be == 8'hF0) push_piece(a, lo, 4, 1'b1, tid, d, pc);
    else if (be == 8'h03 || be == 8'h0C || be == 8'h30 || be == 8'hC0) push_piece(a, lo, 2, 1'b1, tid, d, pc);
    else begin
      for (int k = 0; k < 8; k++) begin
        if (rem[k]) begin
          rem[k] = 1'b0;
          push_piece(a, k, 1, rem == 8'h00, tid, d, pc);
        end
      end
    end
`else
    while (rem != 8'h00) begin
      int sel;
      lo = 0;
      for (int k = 7; k >= 0; k--) if (rem[k]) lo = k;
      sel = 1;
      for (int s = 8; s >= 2; s = s / 2) begin
        bit ok;
        ok = ((lo % s) == 0) && (lo + s <= 8);
        for (int j = 0; j < s; j++) begin
          if (ok && !rem[lo + j]) ok = 1'b0;
        end
        if (ok && sel == 1) sel = s;
      end
      for (int j = 0; j < sel; j++) rem[lo + j] = 1'b0;
      push_piece(a, lo, sel, rem == 8'h00, tid, d, pc);
    end
`endif
  endtask

  task automatic drive_req(input logic [PADDR_W-1:0] a, input logic [7:0] be,
                           input logic [TID_W-1:0] tid, input logic [63:0] d);
    int w = 0;
    @(negedge clk_i);
    while (!req_ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_wait: got ready=%b after %0d cycles, want 1", req_ready_o, w);
    end
    req_valid_i = 1'b1;
    req_paddr_i = a;
    req_be_i    = be;
    req_tid_i   = tid;
    req_data_i  = d;
    push_expected(a, be, tid, d);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    @(negedge clk_i);
    while ((q_exp.size() != 0 || busy_o) && w < budget) begin
      @(negedge clk_i);
      w++;
    end
    total++;
    if (q_exp.size() != 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pieces left busy=%b, want 0 and 0", q_exp.size(), busy_o);
    end
  endtask

  task automatic set_fixed_ready(input bit v);
    ready_mode = 1'b0;
    r_fixed    = v;
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_last_o, busy_o, req_ready_o} !== 4'b0001 ||
        out_paddr_o !== '0 || out_data_o !== '0 || out_size_o !== 2'b00 ||
        out_be_o !== 8'h00 || out_tid_o !== '0) begin
      bad++;
      $display("FAIL reset_values: got v=%b l=%b busy=%b rdy=%b paddr=%h be=%h size=%b tid=%h data=%h, want 0 0 0 1 and zeros",
               out_valid_o, out_last_o, busy_o, req_ready_o, out_paddr_o, out_be_o, out_size_o, out_tid_o, out_data_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_full_dword();
    int nbusy = 0;
    set_fixed_ready(1'b1);
    drive_req(56'h1000, 8'hFF, 2'd1, 64'h0123_4567_89AB_CDEF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (busy_o) nbusy++;
    end
    total++;
    if (nbusy != 1) begin
      bad++;
      $display("FAIL dword_busy_cycles: got %0d, want 1", nbusy);
    end
    wait_idle(20);
  endtask

  task automatic test_sparse();
    int h0;
    int want;
`ifdef WT_STORE_SPLIT_BYTE_ONLY_EN
    want = 6;
`else
    want = 4;
`endif
    set_fixed_ready(1'b1);
    h0 = n_hs;
    drive_req(56'h2008, 8'b0111_1110, 2'd2, 64'hDEAD_BEEF_CAFE_F00D);
    wait_idle(40);
    total++;
    if (n_hs - h0 != want) begin
      bad++;
      $display("FAIL sparse_piece_count: got %0d, want %0d", n_hs - h0, want);
    end
  endtask

  task automatic test_backpressure();
    int h0;
    set_fixed_ready(1'b0);
    h0 = n_hs;
    drive_req(56'h3000, 8'hF0, 2'd3, 64'h1111_2222_3333_4444);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      total++;
      if ({out_valid_o, out_paddr_o[2:0], out_size_o, out_be_o, out_last_o} !== {1'b1, 3'd4, 2'b10, 8'hF0, 1'b1} ||
          out_paddr_o[PADDR_W-1:3] !== 53'(56'h3000 >> 3)) begin
        bad++;
        $display("FAIL backpressure_hold: cycle %0d got v=%b paddr=%h size=%b be=%h last=%b, want 1 3004 10 f0 1",
                 k, out_valid_o, out_paddr_o, out_size_o, out_be_o, out_last_o);
      end
    end
    r_fixed = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    total++;
    if ({req_ready_o, busy_o, out_valid_o} !== 3'b100 || n_hs - h0 != 1) begin
      bad++;
      $display("FAIL backpressure_release: got rdy=%b busy=%b v=%b hs=%0d, want 1 0 0 1",
               req_ready_o, busy_o, out_valid_o, n_hs - h0);
    end
  endtask

  task automatic test_zero_be();
    int h0;
    set_fixed_ready(1'b1);
    h0 = n_hs;
    drive_req(56'h6000, 8'h00, 2'd1, 64'h5555);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      total++;
      if ({out_valid_o, busy_o, req_ready_o} !== 3'b001 || n_hs != h0) begin
        bad++;
        $display("FAIL zero_be_idle: got v=%b busy=%b rdy=%b hs=%0d, want 0 0 1 %0d",
                 out_valid_o, busy_o, req_ready_o, n_hs, h0);
      end
    end
  endtask

  task automatic test_reset_mid_split();
    int h0;
    set_fixed_ready(1'b1);
    drive_req(56'h4000, 8'h55, 2'd2, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({out_valid_o, out_last_o, busy_o, req_ready_o} !== 4'b0001 || out_be_o !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got v=%b l=%b busy=%b rdy=%b be=%h, want 0 0 0 1 00",
               out_valid_o, out_last_o, busy_o, req_ready_o, out_be_o);
    end
    q_exp.delete();
    pieces_in_req = 0;
    prev_off = -1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    h0 = n_hs;
    drive_req(56'h5000, 8'h03, 2'd3, 64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_size_o, out_be_o, out_last_o, out_tid_o} !== {1'b1, 2'b01, 8'h03, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL post_reset_piece: got v=%b size=%b be=%h last=%b tid=%h, want 1 01 03 1 3",
               out_valid_o, out_size_o, out_be_o, out_last_o, out_tid_o);
    end
    wait_idle(20);
    total++;
    if (n_hs - h0 != 1) begin
      bad++;
      $display("FAIL post_reset_count: got %0d, want 1", n_hs - h0);
    end
  endtask

  task automatic test_random();
    ready_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      drive_req({$urandom(), $urandom()} & {PADDR_W{1'b1}}, 8'($urandom_range(255)),
                TID_W'($urandom_range(3)), {$urandom(), $urandom()});
    end
    wait_idle(200);
    ready_mode = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_paddr_i = '0;
    req_data_i  = '0;
    req_be_i    = '0;
    req_tid_i   = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    test_reset();
    test_full_dword();
    test_sparse();
    test_backpressure();
    test_zero_be();
    test_reset_mid_split();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
